// File: rtl/c7bbiu_rd_arb_rr.sv
// c7bbiu_rd_arb_rr: read-request arbiter feeding a single AXI AR channel.
// Up to NREQ requesters compete (round-robin or fixed priority) for a
// registered AR holding slot; per-requester outstanding counters limit the
// number of reads in flight and are retired by rd_done pulses.
module c7bbiu_rd_arb_rr #(
    parameter int NREQ      = 2,
    parameter int AW        = 32,
    parameter int MAX_OUT   = 2,
    parameter int FIXED_PRI = 0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NREQ-1:0]    req_val,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*8-1:0]  req_len,
    output logic [NREQ-1:0]    req_ack,
    output logic               axi_ar_valid,
    input  logic               axi_ar_ready,
    output logic [3:0]         axi_ar_id,
    output logic [AW-1:0]      axi_ar_addr,
    output logic [7:0]         axi_ar_len,
    output logic [2:0]         axi_ar_size,
    output logic [1:0]         axi_ar_burst,
    output logic               axi_ar_lock,
    output logic [3:0]         axi_ar_cache,
    output logic [2:0]         axi_ar_prot,
    input  logic               rd_done_val,
    input  logic [3:0]         rd_done_id
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_OUT);

    logic [2:0]      out_cnt [NREQ];
    logic [NREQ-1:0] elig;
    logic            slot_free;
    logic            gnt_any;
    logic [1:0]      gnt_idx;
    logic [1:0]      rr_ptr;
    logic [1:0]      ptr_next;
    logic [1:0]      start;
    logic [AW-1:0]   sel_addr;
    logic [7:0]      sel_len;

    assign slot_free    = ~axi_ar_valid | axi_ar_ready;
    assign axi_ar_lock  = 1'b0;
    assign axi_ar_cache = 4'b0000;
    assign axi_ar_prot  = 3'b000;

    // Eligibility uses the registered count, so a same-cycle done never unblocks.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req_val[i] && (out_cnt[i] < MAX_CNT);
        end
    end

    // Circular search from the start index: first the upper part, then wrap.
    always_comb begin
        // NOTE: every variable gets a default before any conditional assignment,
        // so no path leaves it unassigned and no latch is inferred.
        gnt_any = 1'b0;
        gnt_idx = 2'd0;
        start   = (FIXED_PRI != 0) ? 2'd0 : rr_ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_any && elig[i] && (2'(i) >= start)) begin
                gnt_any = 1'b1;
                gnt_idx = 2'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_any && elig[i] && (2'(i) < start)) begin
                gnt_any = 1'b1;
                gnt_idx = 2'(i);
            end
        end
        if (!slot_free || !resetn) begin
            gnt_any = 1'b0;
        end
    end

    // Grant decode: one-hot ack, payload mux and the pointer that follows it.
    always_comb begin
        req_ack  = '0;
        sel_addr = '0;
        sel_len  = '0;
        ptr_next = rr_ptr;
        for (int i = 0; i < NREQ; i++) begin
            req_ack[i] = gnt_any && (gnt_idx == 2'(i));
            if (gnt_idx == 2'(i)) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_len  = req_len[i*8 +: 8];
                ptr_next = (i == NREQ - 1) ? 2'd0 : 2'(i + 1);
            end
        end
    end

    // AR holding slot: load on grant, hold while stalled, drop after acceptance.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!resetn) begin
            axi_ar_valid <= 1'b0;
            axi_ar_id    <= '0;
            axi_ar_addr  <= '0;
            axi_ar_len   <= '0;
            axi_ar_size  <= '0;
            axi_ar_burst <= '0;
        end else if (gnt_any) begin
            axi_ar_valid <= 1'b1;
            axi_ar_id    <= {2'b00, gnt_idx};
            axi_ar_addr  <= sel_addr;
            axi_ar_len   <= sel_len;
            axi_ar_size  <= 3'b010;
            axi_ar_burst <= (sel_len != 8'd0) ? 2'b01 : 2'b00;
        end else if (axi_ar_ready) begin
            axi_ar_valid <= 1'b0;
        end
    end

    // Round-robin pointer advances past the winner only when a grant happens.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr <= 2'd0;
        end else if (gnt_any && (FIXED_PRI == 0)) begin
            rr_ptr <= ptr_next;
        end
    end

    // Outstanding counters: +1 on ack, -1 on matching done, ignore done at zero.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: the counter array is small control state that must start at zero,
        // so it is reset element by element (unlike a data RAM, which would not be).
        if (!resetn) begin
            for (int i = 0; i < NREQ; i++) begin
                out_cnt[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ack[i] &&
                    !(rd_done_val && (rd_done_id == 4'(i)) && (out_cnt[i] != 3'd0))) begin
                    out_cnt[i] <= out_cnt[i] + 3'd1;
                end else if (!req_ack[i] && rd_done_val && (rd_done_id == 4'(i)) &&
                             (out_cnt[i] != 3'd0)) begin
                    out_cnt[i] <= out_cnt[i] - 3'd1;
                end
            end
        end
    end

endmodule

// File: doc/c7bbiu_rd_arb_rr.md
C7BBIU_RD_ARB_RR -- requirements
Module: c7bbiu_rd_arb_rr

Interface
REQ-001 Parameter NREQ, default 2, number of read requesters (legal 2..4).
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter MAX_OUT, default 2, maximum outstanding reads per requester (legal 1..7).
REQ-004 Parameter FIXED_PRI, default 0, 1 = fixed priority (lowest index wins), 0 = round-robin.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 resetn  input  1  asynchronous active-low reset.
REQ-007 req_val  input  NREQ  per-requester read request, held until acked.
REQ-008 req_addr  input  NREQ*AW  per-requester address, slice i = bits [i*AW +: AW].
REQ-009 req_len  input  NREQ*8  per-requester AXI burst length (beats-1).
REQ-010 req_ack  output  NREQ  one-hot grant pulse, one cycle per accepted request.
REQ-011 axi_ar_valid  output  1  AR channel valid.
REQ-012 axi_ar_ready  input  1  AR channel ready.
REQ-013 axi_ar_id / addr / len / size / burst / lock / cache / prot  output  4/AW/8/3/2/1/4/3  AR payload.
REQ-014 rd_done_val  input  1  one-cycle pulse: last R beat of a burst accepted.
REQ-015 rd_done_id  input  4  ID of that completed burst.

Function
REQ-016 Requester i SHALL be eligible when req_val[i]=1 and its outstanding count < MAX_OUT.
REQ-017 AR output SHALL be a registered holding slot; slot is free when axi_ar_valid=0 or (axi_ar_valid & axi_ar_ready).
REQ-018 When slot free and any requester eligible, exactly one req_ack bit SHALL assert combinationally that cycle; payload loads next edge and axi_ar_valid=1 next cycle.
REQ-019 Acceptance and new grant in the same cycle SHALL be allowed (one AR per cycle sustained).
REQ-020 When slot not free, req_ack SHALL be 0 and AR payload SHALL hold stable while axi_ar_valid & ~axi_ar_ready.
REQ-021 axi_ar_valid SHALL clear the edge after acceptance when no new grant occurs.
REQ-022 FIXED_PRI=1: lowest eligible index SHALL win.
REQ-023 FIXED_PRI=0: search SHALL start at pointer p, increasing index mod NREQ; after grant to i, p SHALL become (i+1) mod NREQ; p unchanged when no grant.
REQ-024 axi_ar_id SHALL be granted index zero-extended to 4 bits; addr/len from granted slices.
REQ-025 Fixed fields: size=3'b010, burst=2'b01 if len!=0 else 2'b00, lock=0, cache=4'b0000, prot=3'b000.
REQ-026 Outstanding counter i SHALL +1 on req_ack[i], -1 on rd_done_val with rd_done_id==i; both same cycle -> unchanged.
REQ-027 rd_done with id >= NREQ, or to a counter at 0, SHALL be ignored (no underflow).
REQ-028 Counter at MAX_OUT SHALL block requester i until a done arrives; done in same cycle SHALL NOT unblock that cycle (eligibility uses registered count).
REQ-029 rd_done_val SHALL be independent of AR slot state.

Reset
REQ-030 resetn low SHALL asynchronously force axi_ar_valid=0, AR payload=0, p=0, all counters=0; req_ack=0 while resetn low.
REQ-031 Reset mid-transfer SHALL drop a pending AR without completing it; first grant after release uses p=0.

Verification
REQ-032 RR, NREQ=2, req_val=2'b11 continuous, ar_ready=1, done returned each cycle -> ack sequence 01,10,01,10; ar_id 0,1,0,1.
REQ-033 Backpressure: grant req0 addr 0x1000, ar_ready=0 for 3 cycles -> ar_valid=1, addr 0x1000 stable, req_ack=0 for 3 cycles; accept on 4th, new grant same cycle.
REQ-034 MAX_OUT=2, req0 only, no done -> exactly 2 acks then blocked; one done id 0 -> third ack the cycle after.
REQ-035 FIXED_PRI=1, NREQ=4, req_val=4'b1110 -> req_ack=4'b0010 repeatedly; req3 starved while req1 eligible.
REQ-036 len=0 -> burst 2'b00; len=8'h07 -> burst 2'b01; size always 3'b010.
REQ-037 Assert resetn low while ar_valid=1 -> ar_valid=0 immediately; counters 0; after release req_val=2'b10 -> ack 10, ar_id 1.
